// File: rtl/dual_fetch_queue_if.sv
// Fetch-queue port bundle: instruction-memory request/response, redirect,
// hazard stalls, and the two decode issue slots.
interface dual_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_a;
  logic        stall_b;
  logic        id_valid_a;
  logic        id_valid_b;
  logic [31:0] id_instr_a;
  logic [31:0] id_instr_b;
  logic [31:0] id_pc_a;
  logic [31:0] id_pc_b;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, stall_a, stall_b,
    output id_valid_a, id_valid_b, id_instr_a, id_instr_b, id_pc_a, id_pc_b
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, stall_a, stall_b,
    input  id_valid_a, id_valid_b, id_instr_a, id_instr_b, id_pc_a, id_pc_b
  );
endinterface

// File: rtl/dual_fetch_queue.sv
// Dual-issue fetch queue: fetches 8-byte instruction pairs, buffers them in a
// circular queue, and presents the two oldest entries to decode slots A/B.
module dual_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input logic                clk,
  input logic                rst_n,
  dual_fetch_queue_if.master fq
);
  localparam int PW = $clog2(QDEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  logic [QDEPTH-1:0][31:0] pc_q, instr_q;
  ptr_t        head, tail, head1, tail1;
  cnt_t        count, push_n, pop_n;
  logic [31:0] fetch_pc, rsp_pc;
  logic        outstanding, drop_pending, discard, stale;
  logic        req_fire, rsp_live, rsp_push, out_after;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^fq.redirect_pc[1:0];

  assign head1     = head + ptr_t'(1);
  assign tail1     = tail + ptr_t'(1);
  assign req_fire  = fq.imem_req_valid & fq.imem_req_ready;
  // A response seen while stale belongs to a request issued before reset.
  assign rsp_live  = fq.imem_rsp_valid & ~stale;
  assign rsp_push  = rsp_live & ~drop_pending & ~fq.redirect_valid;
  assign push_n    = rsp_push ? (discard ? cnt_t'(1) : cnt_t'(2)) : '0;
  assign out_after = outstanding & ~rsp_live;

  always_comb begin
    pop_n = '0;
    if (!fq.stall_a) begin
      if (fq.stall_b) pop_n = (count != '0) ? cnt_t'(1) : '0;
      else            pop_n = (count >= cnt_t'(2)) ? cnt_t'(2) : count;
    end
  end

  assign fq.imem_req_valid = rst_n & ~outstanding & ~drop_pending & ~fq.redirect_valid
                           & ((cnt_t'(QDEPTH) - count) >= cnt_t'(2));
  assign fq.imem_req_addr  = fetch_pc;
  assign fq.id_valid_a     = rst_n & (count >= cnt_t'(1));
  assign fq.id_valid_b     = rst_n & (count >= cnt_t'(2));
  assign fq.id_instr_a     = rst_n ? instr_q[head]  : '0;
  assign fq.id_instr_b     = rst_n ? instr_q[head1] : '0;
  assign fq.id_pc_a        = rst_n ? pc_q[head]     : '0;
  assign fq.id_pc_b        = rst_n ? pc_q[head1]    : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc     <= {RESET_PC[31:3], 3'b000};
      discard      <= RESET_PC[2];
      rsp_pc       <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      outstanding  <= 1'b0;
      drop_pending <= 1'b0;
      pc_q         <= '0;
      instr_q      <= '0;
      // Remember an in-flight request across reset so its response is ignored.
      stale        <= (stale & outstanding) | ((stale | outstanding) & ~fq.imem_rsp_valid);
    end else begin
      if (fq.imem_rsp_valid && stale) stale <= 1'b0;
      if (fq.redirect_valid) begin
        head         <= tail;
        count        <= '0;
        fetch_pc     <= {fq.redirect_pc[31:3], 3'b000};
        discard      <= fq.redirect_pc[2];
        outstanding  <= out_after;
        drop_pending <= out_after;
      end else begin
        if (req_fire) begin
          fetch_pc    <= fetch_pc + 32'd8;
          rsp_pc      <= fetch_pc;
          outstanding <= 1'b1;
        end else if (rsp_live) begin
          outstanding <= 1'b0;
        end
        if (rsp_live) drop_pending <= 1'b0;
        if (rsp_push) begin
          if (discard) begin
            pc_q[tail]    <= rsp_pc + 32'd4;
            instr_q[tail] <= fq.imem_rsp_data[63:32];
            discard       <= 1'b0;
          end else begin
            pc_q[tail]     <= rsp_pc;
            instr_q[tail]  <= fq.imem_rsp_data[31:0];
            pc_q[tail1]    <= rsp_pc + 32'd4;
            instr_q[tail1] <= fq.imem_rsp_data[63:32];
          end
        end
        tail  <= tail + ptr_t'(push_n);
        head  <= head + ptr_t'(pop_n);
        count <= count + push_n - pop_n;
      end
    end
  end
endmodule

// File: tb/tb_dual_fetch_queue.sv
// Directed bench for dual_fetch_queue: fill/stall, partial pop, redirect with
// stale and same-cycle responses, PC wrap, and reset with a request in flight.
module tb_dual_fetch_queue;
  logic clk = 1'b0;
  logic rst_n;
  logic auto_mem;
  int   n_cmp = 0;
  int   n_err = 0;

  dual_fetch_queue_if fq();

  dual_fetch_queue dut (.clk(clk), .rst_n(rst_n), .fq(fq));

  always #5 clk = ~clk;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; the memory model answers an accepted request on the next cycle.
  task automatic cyc();
    logic        fire;
    logic [31:0] a;
    @(negedge clk);
    fire = fq.imem_req_valid & fq.imem_req_ready;
    a    = fq.imem_req_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      fq.imem_rsp_valid = fire;
      fq.imem_rsp_data  = {w(a + 32'd4), w(a)};
    end
  endtask

  task automatic stalls(input logic a, input logic b);
    fq.stall_a = a;
    fq.stall_b = b;
  endtask

  initial begin
    rst_n = 1'b0;
    auto_mem = 1'b1;
    fq.imem_req_ready = 1'b1;
    fq.imem_rsp_valid = 1'b0;
    fq.imem_rsp_data  = '0;
    fq.redirect_valid = 1'b0;
    fq.redirect_pc    = '0;
    stalls(1'b1, 1'b1);
    cyc(); cyc();
    chk("rst_va",    32'(fq.id_valid_a), 32'd0);
    chk("rst_vb",    32'(fq.id_valid_b), 32'd0);
    chk("rst_req",   32'(fq.imem_req_valid), 32'd0);
    chk("rst_instr", fq.id_instr_a, 32'd0);
    chk("rst_pc",    fq.id_pc_b, 32'd0);

    // First fetch and 1-cycle memory
    rst_n = 1'b1; #1;
    chk("req0_v", 32'(fq.imem_req_valid), 32'd1);
    chk("req0_a", fq.imem_req_addr, 32'h0);
    cyc();
    chk("busy_noreq", 32'(fq.imem_req_valid), 32'd0);
    cyc();
    chk("a_v",   32'(fq.id_valid_a), 32'd1);
    chk("a_pc",  fq.id_pc_a, 32'h0);
    chk("a_ins", fq.id_instr_a, 32'h5A5A_0000);
    chk("b_v",   32'(fq.id_valid_b), 32'd1);
    chk("b_pc",  fq.id_pc_b, 32'h4);
    chk("b_ins", fq.id_instr_b, 32'h5A5A_0004);
    chk("req1_v", 32'(fq.imem_req_valid), 32'd1);
    chk("req1_a", fq.imem_req_addr, 32'h8);

    // Fill to 4 entries with stalls held
    cyc(); cyc();
    chk("full_noreq", 32'(fq.imem_req_valid), 32'd0);
    cyc(); cyc();
    chk("full_pc_a",  fq.id_pc_a, 32'h0);
    chk("full_pc_b",  fq.id_pc_b, 32'h4);
    chk("full_ins_b", fq.id_instr_b, 32'h5A5A_0004);
    chk("full_noreq2", 32'(fq.imem_req_valid), 32'd0);

    // Dual pops, refill to 10/14/18/1C
    stalls(1'b0, 1'b0); cyc(); stalls(1'b1, 1'b1);
    chk("pop2_pc_a", fq.id_pc_a, 32'h8);
    chk("pop2_req",  fq.imem_req_addr, 32'h10);
    cyc(); cyc();
    stalls(1'b0, 1'b0); cyc(); stalls(1'b1, 1'b1);
    chk("req18", fq.imem_req_addr, 32'h18);
    cyc(); cyc();
    chk("q10_pc_a", fq.id_pc_a, 32'h10);

    // Single pop: B moves to A
    stalls(1'b0, 1'b1); cyc(); stalls(1'b1, 1'b1);
    chk("pop1_pc_a",  fq.id_pc_a, 32'h14);
    chk("pop1_pc_b",  fq.id_pc_b, 32'h18);
    chk("pop1_ins_b", fq.id_instr_b, 32'h5A5A_0018);

    // Redirect with a request outstanding
    stalls(1'b0, 1'b0); cyc(); stalls(1'b1, 1'b1);
    chk("req20", fq.imem_req_addr, 32'h20);
    auto_mem = 1'b0;
    cyc();
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h104; #1;
    chk("redir_noreq", 32'(fq.imem_req_valid), 32'd0);
    cyc();
    fq.redirect_valid = 1'b0; #1;
    chk("flush_va",   32'(fq.id_valid_a), 32'd0);
    chk("drop_noreq", 32'(fq.imem_req_valid), 32'd0);
    fq.imem_rsp_valid = 1'b1; fq.imem_rsp_data = {w(32'h24), w(32'h20)};
    cyc();
    fq.imem_rsp_valid = 1'b0; #1;
    chk("stale_va",  32'(fq.id_valid_a), 32'd0);
    chk("req100_v",  32'(fq.imem_req_valid), 32'd1);
    chk("req100_a",  fq.imem_req_addr, 32'h100);
    auto_mem = 1'b1;
    cyc(); cyc();
    chk("odd_va",   32'(fq.id_valid_a), 32'd1);
    chk("odd_pc",   fq.id_pc_a, 32'h104);
    chk("odd_ins",  fq.id_instr_a, 32'h5A5A_0104);
    chk("odd_vb",   32'(fq.id_valid_b), 32'd0);

    // Fetch PC wraps past 2^32
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'hFFFF_FFF8;
    cyc();
    fq.redirect_valid = 1'b0; #1;
    chk("wrap_va",  32'(fq.id_valid_a), 32'd0);
    chk("wrap_req", fq.imem_req_addr, 32'hFFFF_FFF8);
    cyc(); cyc();
    chk("wrap_pc_a",  fq.id_pc_a, 32'hFFFF_FFF8);
    chk("wrap_ins_a", fq.id_instr_a, 32'hA5A5_FFF8);
    chk("wrap_pc_b",  fq.id_pc_b, 32'hFFFF_FFFC);
    chk("wrap_next",  fq.imem_req_addr, 32'h0);

    // Redirect, response and pop in the same cycle
    cyc();
    chk("same_rsp", 32'(fq.imem_rsp_valid), 32'd1);
    fq.redirect_valid = 1'b1; fq.redirect_pc = 32'h200; stalls(1'b0, 1'b0);
    cyc();
    fq.redirect_valid = 1'b0; stalls(1'b1, 1'b1); #1;
    chk("same_va",  32'(fq.id_valid_a), 32'd0);
    chk("same_vb",  32'(fq.id_valid_b), 32'd0);
    chk("same_req", 32'(fq.imem_req_valid), 32'd1);
    chk("same_adr", fq.imem_req_addr, 32'h200);
    cyc(); cyc();
    chk("r200_pc_a",  fq.id_pc_a, 32'h200);
    chk("r200_pc_b",  fq.id_pc_b, 32'h204);
    chk("r200_ins_a", fq.id_instr_a, 32'h5A5A_0200);

    // Reset with a request in flight
    auto_mem = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    chk("mrst_va",  32'(fq.id_valid_a), 32'd0);
    chk("mrst_req", 32'(fq.imem_req_valid), 32'd0);
    chk("mrst_ins", fq.id_instr_a, 32'd0);
    rst_n = 1'b1; #1;
    chk("post_req_v", 32'(fq.imem_req_valid), 32'd1);
    chk("post_req_a", fq.imem_req_addr, 32'h0);
    cyc();
    fq.imem_rsp_valid = 1'b1; fq.imem_rsp_data = {w(32'h20C), w(32'h208)};
    cyc();
    fq.imem_rsp_valid = 1'b0; #1;
    chk("post_stale_va", 32'(fq.id_valid_a), 32'd0);
    chk("post_noreq",    32'(fq.imem_req_valid), 32'd0);
    fq.imem_rsp_valid = 1'b1; fq.imem_rsp_data = {w(32'h4), w(32'h0)};
    cyc();
    fq.imem_rsp_valid = 1'b0; #1;
    chk("post_pc_a",  fq.id_pc_a, 32'h0);
    chk("post_ins_a", fq.id_instr_a, 32'h5A5A_0000);
    chk("post_pc_b",  fq.id_pc_b, 32'h4);
    chk("post_ins_b", fq.id_instr_b, 32'h5A5A_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dual_fetch_queue.md
DUAL_FETCH_QUEUE -- requirements
Module: dual_fetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter QDEPTH, default 4: fetch-queue entries; power of two, at least 4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 imem_req_valid  out  1  fetch-pair request.
REQ-006 imem_req_ready  in  1  memory accepts request.
REQ-007 imem_req_addr  out  32  pair address, 8-byte aligned.
REQ-008 imem_rsp_valid  in  1  response data valid; arrives 1 or more cycles after acceptance.
REQ-009 imem_rsp_data  in  64  [31:0] instr at addr, [63:32] instr at addr+4.
REQ-010 redirect_valid  in  1  branch/JAL taken; flush and refetch.
REQ-011 redirect_pc  in  32  new PC, 4-byte aligned.
REQ-012 stall_a  in  1  hazard unit: slot A stalled (A_STALL/B_STALL); implies B held.
REQ-013 stall_b  in  1  hazard unit: slot B held (HOLD_B/STALL_FROM_A).
REQ-014 id_valid_a, id_valid_b  out  1 each  issue-slot valid to decode.
REQ-015 id_instr_a, id_instr_b  out  32 each  instruction words.
REQ-016 id_pc_a, id_pc_b  out  32 each  instruction PCs.

Function
REQ-017 The queue SHALL be a circular buffer of QDEPTH {pc, instr} entries with head and tail pointers that wrap modulo QDEPTH, plus a count of 0..QDEPTH.
REQ-018 Slot A SHALL present the head entry and slot B SHALL present head+1, both driven directly from storage.
REQ-019 id_valid_a SHALL equal (count>=1) and id_valid_b SHALL equal (count>=2).
REQ-020 imem_req_valid SHALL assert only when no request is outstanding, no redirect is asserted this cycle, and (QDEPTH - count) >= 2.
REQ-021 On request handshake, fetch_pc SHALL advance by 8, wrapping modulo 2^32, and an outstanding flag SHALL be set.
REQ-022 A non-dropped response SHALL push both words in address order and clear the outstanding flag.
REQ-023 If the first-word-discard flag is set, the response SHALL push only [63:32] and then clear that flag.
REQ-024 Pushed data SHALL be visible on id_* the cycle after imem_rsp_valid (1-cycle latency).
REQ-025 Pop count SHALL be:
  - 0 if stall_a=1;
  - 1 if stall_a=0 and stall_b=1, so B moves into slot A next cycle;
  - min(count,2) if both stalls are 0.
REQ-026 Push and pop in the same cycle SHALL both take effect; count SHALL never exceed QDEPTH or go below 0.
REQ-027 On redirect_valid, in the same cycle the block SHALL:
  - empty the queue (count=0);
  - set fetch_pc = {redirect_pc[31:3],3'b000};
  - set the discard flag = redirect_pc[2];
  - set drop_pending if a request is outstanding or is being accepted that cycle.
REQ-028 Redirect SHALL take priority over push, pop and stall in the same cycle.
REQ-029 With drop_pending set, the next response SHALL be discarded and clear drop_pending and the outstanding flag.
REQ-030 No new request SHALL issue while drop_pending=1.
REQ-031 imem_req_addr SHALL equal fetch_pc and SHALL hold stable while imem_req_valid=1 and imem_req_ready=0.

Reset
REQ-032 While rst_n=0 at a rising edge, the block SHALL set:
  - fetch_pc=RESET_PC aligned down to 8 bytes; discard flag=RESET_PC[2];
  - count=0, head=tail=0;
  - outstanding=0, drop_pending=0.
REQ-033 During reset, all id_valid_* and imem_req_valid SHALL be 0, and id_instr_*/id_pc_* SHALL be 0.
REQ-034 A response arriving after a mid-operation reset SHALL be discarded if its request was outstanding at reset.
REQ-035 The first request after reset SHALL issue on the first cycle with rst_n=1.

Verification
REQ-036 Reset release, ready=1, 1-cycle memory -> req addr 0x0, then 0x8; next cycle A=(0x0,I0), B=(0x4,I1), both valid.
REQ-037 Queue full (4 entries), stalls held at 1 -> imem_req_valid=0, outputs unchanged, no overflow.
REQ-038 stall_a=0, stall_b=1 with entries at 0x10/0x14/0x18 -> next cycle A=(0x14), B=(0x18).
REQ-039 Redirect to 0x104 while a request is outstanding -> queue empties; stale response dropped; next req 0x100; only 0x104 enqueued, in slot A.
REQ-040 fetch_pc=0xFFFFFFF8 accepted -> next req addr 0x00000000.
REQ-041 Redirect, response and pop all in one cycle -> queue empty next cycle, response not enqueued.
